// File: rtl/app_burst_engine_pkg.sv
// Shared definitions for the burst engine: FSM states, MIG commands, run modes, LFSR.
// No logic of its own; the LFSR step is a pure function.
// No flow control; the users of these definitions handle it.
package app_burst_engine_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WR    = 3'd1,
    ST_RD    = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  localparam logic [1:0] MODE_WR  = 2'b00;
  localparam logic [1:0] MODE_RD  = 2'b01;
  localparam logic [1:0] MODE_WRC = 2'b10;
  localparam logic [1:0] MODE_RSV = 2'b11;

  // x^32 + x^22 + x^2 + x + 1, left-shifting Galois form (taps at bits 22, 2, 1, 0)
  localparam logic [31:0] LFSR_POLY = 32'h0040_0007;
  localparam logic [31:0] LFSR_SEED = 32'h0000_0001;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[30:0], 1'b0} ^ (s[31] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/app_burst_engine_pat.sv
// Pattern word generator: beat index or LFSR state expanded to a full app data word.
// Purely combinational, zero latency.
// No flow control; the caller holds the index/LFSR state while stalled.
module app_pattern_gen
  import app_burst_engine_pkg::*;
#(
  parameter int DATA_W = 256,
  parameter int LEN_W  = 8
) (
  input  logic              i_pat_sel,
  input  logic [LEN_W-1:0]  i_idx,
  input  logic [31:0]       i_lfsr,
  output logic [DATA_W-1:0] o_data
);

  // incrementing: index zero-extended; LFSR: state replicated across 32-bit lanes
  always_comb begin
    o_data = '0;
    if (i_pat_sel) begin
      o_data = {(DATA_W/32){i_lfsr}};
    end else begin
      o_data[LEN_W-1:0] = i_idx;
    end
  end

endmodule

// File: rtl/app_burst_engine.sv
// MIG app-interface burst engine: writes a pattern burst, reads it back, compares.
// Commands issue from registered state; first write data is presented the cycle after start.
// Holds app_en/app_wdf_wren with their payload until app_rdy/app_wdf_rdy; read data is never stalled.
module app_burst_engine
  import app_burst_engine_pkg::*;
#(
  parameter int DATA_W    = 256,
  parameter int ADDR_W    = 29,
  parameter int ADDR_STEP = 8,
  parameter int LEN_W     = 8,
  parameter int TIMEOUT   = 1024
) (
  input  logic                ui_clk,
  input  logic                ui_clk_sync_rst,
  input  logic                init_calib_complete,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic                pat_sel,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [LEN_W-1:0]    burst_len,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [LEN_W-1:0]    err_count,
  output logic [ADDR_W-1:0]   first_err_addr,
  output logic [ADDR_W-1:0]   app_addr,
  output logic [2:0]          app_cmd,
  output logic                app_en,
  output logic [DATA_W-1:0]   app_wdf_data,
  output logic                app_wdf_wren,
  output logic                app_wdf_end,
  output logic [DATA_W/8-1:0] app_wdf_mask,
  input  logic                app_rdy,
  input  logic                app_wdf_rdy,
  input  logic                app_rd_data_valid,
  input  logic [DATA_W-1:0]   app_rd_data
);

  localparam int              TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);

  state_t              r_state, w_next;
  logic [1:0]          r_mode;
  logic                r_pat;
  logic [ADDR_W-1:0]   r_base, r_addr, r_rd_addr, r_first_err_addr;
  logic [LEN_W-1:0]    r_len, r_dat_cnt, r_cmd_cnt, r_rd_cnt, r_err_count;
  logic [31:0]         r_wr_lfsr, r_cmp_lfsr;
  logic                r_en, r_wren, r_error;
  logic [TMR_W-1:0]    r_timer;

  logic                w_dat_acc, w_cmd_acc, w_rd_acc, w_mismatch;
  logic                w_skip, w_drained, w_timeout;
  logic [LEN_W-1:0]    w_dat_cnt_n, w_cmd_cnt_n, w_rd_cnt_n;
  logic [DATA_W-1:0]   w_wr_pat, w_cmp_pat;

  assign w_dat_acc   = r_wren & app_wdf_rdy;
  assign w_cmd_acc   = r_en & app_rdy;
  // read beats are counted in RD as well as DRAIN; anything past burst_len is surplus
  assign w_rd_acc    = app_rd_data_valid & ((r_state == ST_RD) | (r_state == ST_DRAIN))
                       & (r_rd_cnt != r_len);
  assign w_dat_cnt_n = w_dat_acc ? r_dat_cnt + LEN_W'(1) : r_dat_cnt;
  assign w_cmd_cnt_n = w_cmd_acc ? r_cmd_cnt + LEN_W'(1) : r_cmd_cnt;
  assign w_rd_cnt_n  = w_rd_acc  ? r_rd_cnt  + LEN_W'(1) : r_rd_cnt;
  assign w_skip      = (mode == MODE_RSV) | (burst_len == '0);
  assign w_drained   = (w_rd_cnt_n == r_len);
  assign w_timeout   = (r_state == ST_DRAIN) & ~w_drained & (r_timer == TMR_W'(TIMEOUT - 1));
  assign w_mismatch  = w_rd_acc & (r_mode == MODE_WRC) & (app_rd_data != w_cmp_pat);

  app_pattern_gen #(.DATA_W(DATA_W), .LEN_W(LEN_W)) u_wr_pat (
    .i_pat_sel (r_pat),
    .i_idx     (r_dat_cnt),
    .i_lfsr    (r_wr_lfsr),
    .o_data    (w_wr_pat)
  );

  app_pattern_gen #(.DATA_W(DATA_W), .LEN_W(LEN_W)) u_cmp_pat (
    .i_pat_sel (r_pat),
    .i_idx     (r_rd_cnt),
    .i_lfsr    (r_cmp_lfsr),
    .o_data    (w_cmp_pat)
  );

  // state register
  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) r_state <= ST_IDLE;
    else                 r_state <= w_next;
  end

  // next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start && init_calib_complete)
                  w_next = w_skip ? ST_FIN : ((mode == MODE_RD) ? ST_RD : ST_WR);
      ST_WR:    if (w_cmd_acc && (w_cmd_cnt_n == r_len))
                  w_next = (r_mode == MODE_WRC) ? ST_RD : ST_FIN;
      ST_RD:    if (w_cmd_acc && (w_cmd_cnt_n == r_len)) w_next = ST_DRAIN;
      ST_DRAIN: if (w_drained || w_timeout) w_next = ST_FIN;
      ST_FIN:   w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // status and command-type outputs decoded from state
  always_comb begin
    busy    = (r_state != ST_IDLE);
    done    = (r_state == ST_FIN);
    app_cmd = (r_state == ST_WR) ? CMD_WR : CMD_RD;
  end

  // datapath: run setup, write/command issue, read-back compare, drain timer
  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      r_mode <= MODE_WR;  r_pat <= 1'b0;  r_base <= '0;  r_len <= '0;
      r_addr <= '0;  r_rd_addr <= '0;  r_first_err_addr <= '0;
      r_dat_cnt <= '0;  r_cmd_cnt <= '0;  r_rd_cnt <= '0;  r_err_count <= '0;
      r_wr_lfsr <= LFSR_SEED;  r_cmp_lfsr <= LFSR_SEED;
      r_en <= 1'b0;  r_wren <= 1'b0;  r_error <= 1'b0;  r_timer <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (start && init_calib_complete) begin
          r_mode <= mode;  r_pat <= pat_sel;  r_base <= base_addr;  r_len <= burst_len;
          r_addr <= base_addr;  r_rd_addr <= base_addr;  r_first_err_addr <= '0;
          r_dat_cnt <= '0;  r_cmd_cnt <= '0;  r_rd_cnt <= '0;  r_err_count <= '0;
          r_wr_lfsr <= LFSR_SEED;  r_cmp_lfsr <= LFSR_SEED;
          r_error <= 1'b0;  r_timer <= '0;
          r_wren <= ~w_skip & (mode != MODE_RD);
          r_en   <= ~w_skip & (mode == MODE_RD);
        end
        ST_WR: begin
          // data runs ahead; a write command only follows an already accepted beat
          r_dat_cnt <= w_dat_cnt_n;
          r_cmd_cnt <= w_cmd_cnt_n;
          if (w_dat_acc) r_wr_lfsr <= lfsr_next(r_wr_lfsr);
          if (w_cmd_acc) r_addr <= r_addr + STEP;
          r_wren <= (w_dat_cnt_n != r_len);
          r_en   <= (w_cmd_cnt_n != w_dat_cnt_n);
          if (w_next == ST_RD) begin
            r_addr    <= r_base;
            r_cmd_cnt <= '0;
            r_en      <= 1'b1;
          end
        end
        ST_RD: begin
          r_cmd_cnt <= w_cmd_cnt_n;
          if (w_cmd_acc) r_addr <= r_addr + STEP;
          r_en <= (w_cmd_cnt_n != r_len);
        end
        ST_DRAIN: r_timer <= r_timer + TMR_W'(1);
        default: ;
      endcase

      if (w_rd_acc) begin
        r_rd_cnt   <= w_rd_cnt_n;
        r_rd_addr  <= r_rd_addr + STEP;
        r_cmp_lfsr <= lfsr_next(r_cmp_lfsr);
      end
      if (w_mismatch) begin
        if (r_err_count != '1) r_err_count <= r_err_count + LEN_W'(1);
        if (r_err_count == '0) r_first_err_addr <= r_rd_addr;
        r_error <= 1'b1;
      end
      if (w_timeout) r_error <= 1'b1;
    end
  end

  assign app_en         = r_en;
  assign app_addr       = r_addr;
  assign app_wdf_wren   = r_wren;
  assign app_wdf_end    = r_wren;
  assign app_wdf_mask   = '0;
  assign app_wdf_data   = r_wren ? w_wr_pat : '0;
  assign err_count      = r_err_count;
  assign first_err_addr = r_first_err_addr;
  assign error          = r_error;

endmodule

// File: tb/tb_app_burst_engine.sv
// Directed bench for app_burst_engine with a small MIG memory model.
// Model accepts commands/data per handshake and returns reads one cycle after acceptance.
// app_rdy/app_wdf_rdy can be randomly withheld to exercise stalls.
module tb_app_burst_engine;

  localparam int DATA_W  = 256;
  localparam int ADDR_W  = 29;
  localparam int LEN_W   = 8;
  localparam int TIMEOUT = 1024;

  logic                ui_clk = 1'b0;
  logic                ui_clk_sync_rst = 1'b1;
  logic                init_calib_complete = 1'b1;
  logic                start = 1'b0;
  logic [1:0]          mode = 2'b00;
  logic                pat_sel = 1'b0;
  logic [ADDR_W-1:0]   base_addr = '0;
  logic [LEN_W-1:0]    burst_len = '0;
  logic                busy, done, error;
  logic [LEN_W-1:0]    err_count;
  logic [ADDR_W-1:0]   first_err_addr, app_addr;
  logic [2:0]          app_cmd;
  logic                app_en, app_wdf_wren, app_wdf_end;
  logic [DATA_W-1:0]   app_wdf_data;
  logic [DATA_W/8-1:0] app_wdf_mask;
  logic                app_rdy = 1'b1, app_wdf_rdy = 1'b1, app_rd_data_valid = 1'b0;
  logic [DATA_W-1:0]   app_rd_data = '0;

  always #5 ui_clk = ~ui_clk;

  app_burst_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ADDR_STEP(8), .LEN_W(LEN_W),
                     .TIMEOUT(TIMEOUT)) dut (
    .ui_clk(ui_clk), .ui_clk_sync_rst(ui_clk_sync_rst),
    .init_calib_complete(init_calib_complete), .start(start), .mode(mode),
    .pat_sel(pat_sel), .base_addr(base_addr), .burst_len(burst_len),
    .busy(busy), .done(done), .error(error), .err_count(err_count),
    .first_err_addr(first_err_addr), .app_addr(app_addr), .app_cmd(app_cmd),
    .app_en(app_en), .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren),
    .app_wdf_end(app_wdf_end), .app_wdf_mask(app_wdf_mask), .app_rdy(app_rdy),
    .app_wdf_rdy(app_wdf_rdy), .app_rd_data_valid(app_rd_data_valid),
    .app_rd_data(app_rd_data)
  );

  int n_vec = 0, n_miss = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // memory model state
  logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] wdq[$], wr_dat_log[$];
  logic [ADDR_W-1:0] rdq[$], wr_addr_log[$], rd_addr_log[$];
  bit                stall_en = 1'b0;
  int                ret_budget = 1000000, corrupt_idx = -1, ret_num = 0;
  int                stall_err = 0, order_err = 0, proto_err = 0, cmd_cnt = 0;
  time               last_cmd_t = 0;
  bit                prev_en_stall = 1'b0, prev_wd_stall = 1'b0;
  logic [ADDR_W-1:0] prev_addr;
  logic [2:0]        prev_cmd;
  logic [DATA_W-1:0] prev_wd, mon_d, drv_d;
  logic [ADDR_W-1:0] drv_a;

  // monitor: handshakes seen here complete at the following rising edge
  initial forever begin
    @(negedge ui_clk);
    if (ui_clk_sync_rst) begin
      prev_en_stall = 1'b0;
      prev_wd_stall = 1'b0;
    end else begin
      if (prev_en_stall && (!app_en || app_addr !== prev_addr || app_cmd !== prev_cmd)) stall_err++;
      if (prev_wd_stall && (!app_wdf_wren || app_wdf_data !== prev_wd)) stall_err++;
      if (app_wdf_end !== app_wdf_wren || app_wdf_mask !== '0) proto_err++;
      if (app_en && app_rdy) begin
        cmd_cnt++;
        last_cmd_t = $time;
        if (app_cmd == 3'b000) begin
          if (wdq.size() == 0) order_err++;
          else begin
            mon_d = wdq.pop_front();
            mem[app_addr] = mon_d;
            wr_addr_log.push_back(app_addr);
            wr_dat_log.push_back(mon_d);
          end
        end else begin
          rdq.push_back(app_addr);
          rd_addr_log.push_back(app_addr);
        end
      end
      if (app_wdf_wren && app_wdf_rdy) wdq.push_back(app_wdf_data);
      prev_en_stall = app_en && !app_rdy;
      prev_wd_stall = app_wdf_wren && !app_wdf_rdy;
      prev_addr = app_addr;
      prev_cmd  = app_cmd;
      prev_wd   = app_wdf_data;
    end
  end

  // driver: ready randomisation and in-order read return
  initial forever begin
    @(posedge ui_clk);
    #1;
    app_rdy     = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    app_wdf_rdy = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    app_rd_data_valid = 1'b0;
    if (!ui_clk_sync_rst && rdq.size() > 0 && ret_budget > 0) begin
      drv_a = rdq.pop_front();
      drv_d = mem.exists(drv_a) ? mem[drv_a] : '0;
      if (ret_num == corrupt_idx) drv_d[0] = ~drv_d[0];
      app_rd_data = drv_d;
      app_rd_data_valid = 1'b1;
      ret_num++;
      ret_budget--;
    end
  end

  task automatic clear();
    wdq.delete(); rdq.delete(); wr_dat_log.delete(); wr_addr_log.delete(); rd_addr_log.delete();
    cmd_cnt = 0; ret_num = 0; stall_err = 0; order_err = 0; proto_err = 0;
    corrupt_idx = -1; ret_budget = 1000000;
  endtask

  task automatic go(input logic [1:0] m, input logic p, input logic [ADDR_W-1:0] b,
                    input logic [LEN_W-1:0] l);
    @(posedge ui_clk); #1;
    mode = m; pat_sel = p; base_addr = b; burst_len = l; start = 1'b1;
    @(posedge ui_clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit, output time t);
    bit got = 1'b0;
    t = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge ui_clk);
      if (done) begin got = 1'b1; t = $time; break; end
    end
    chk({tag, "_done_seen"}, 256'(got), 256'd1);
  endtask

  time t_done;
  int  bad, n_cmd;

  initial begin
    // reset values
    repeat (3) @(negedge ui_clk);
    chk("rst_busy", 256'(busy), 256'd0);
    chk("rst_done", 256'(done), 256'd0);
    chk("rst_error", 256'(error), 256'd0);
    chk("rst_app_en", 256'(app_en), 256'd0);
    chk("rst_wren", 256'(app_wdf_wren), 256'd0);
    chk("rst_errcnt", 256'(err_count), 256'd0);
    chk("rst_first_err", 256'(first_err_addr), 256'd0);
    chk("rst_addr", 256'(app_addr), 256'd0);
    chk("rst_wdata", 256'(app_wdf_data), 256'd0);
    chk("rst_cmd", 256'(app_cmd), 256'd1);
    @(posedge ui_clk); #1; ui_clk_sync_rst = 1'b0;

    // write-only, incrementing pattern, 4 beats from 0
    clear();
    go(2'b00, 1'b0, '0, 8'd4);
    wait_done("wr4", 100, t_done);
    chk("wr4_ncmd", 256'(wr_addr_log.size()), 256'd4);
    for (int i = 0; i < 4 && i < wr_addr_log.size(); i++) begin
      chk($sformatf("wr4_addr%0d", i), 256'(wr_addr_log[i]), 256'(i * 8));
      chk($sformatf("wr4_data%0d", i), 256'(wr_dat_log[i]), 256'(i));
    end
    chk("wr4_done_lat", 256'(t_done - last_cmd_t), 256'd10);
    chk("wr4_order", 256'(order_err), 256'd0);
    chk("wr4_proto", 256'(proto_err), 256'd0);
    @(negedge ui_clk);
    chk("wr4_done_pulse", 256'(done), 256'd0);
    chk("wr4_idle", 256'(busy), 256'd0);

    // write-then-compare, 16 beats, clean read-back; extra start while busy is ignored
    clear();
    go(2'b10, 1'b0, 29'h100, 8'd16);
    @(posedge ui_clk); #1; mode = 2'b01; burst_len = 8'd3; start = 1'b1;
    @(posedge ui_clk); #1; start = 1'b0;
    wait_done("wrc16", 300, t_done);
    chk("wrc16_nrd", 256'(rd_addr_log.size()), 256'd16);
    chk("wrc16_rd_last", 256'(rd_addr_log.size() == 16 ? rd_addr_log[15] : '0), 256'h178);
    chk("wrc16_errcnt", 256'(err_count), 256'd0);
    chk("wrc16_error", 256'(error), 256'd0);

    // write-then-compare, 8 beats, beat 5 corrupted on return
    clear();
    corrupt_idx = 5;
    go(2'b10, 1'b0, 29'h200, 8'd8);
    wait_done("wrc8", 200, t_done);
    chk("wrc8_errcnt", 256'(err_count), 256'd1);
    chk("wrc8_first_err", 256'(first_err_addr), 256'h228);
    chk("wrc8_error", 256'(error), 256'd1);
    repeat (4) @(negedge ui_clk);
    chk("wrc8_error_held", 256'(error), 256'd1);

    // 50% stalls on both ready inputs, LFSR pattern, 34 beats
    clear();
    stall_en = 1'b1;
    go(2'b10, 1'b1, 29'h1000, 8'd34);
    wait_done("lfsr", 2000, t_done);
    stall_en = 1'b0;
    chk("lfsr_nwr", 256'(wr_addr_log.size()), 256'd34);
    chk("lfsr_nrd", 256'(rd_addr_log.size()), 256'd34);
    bad = 0;
    for (int i = 0; i < wr_addr_log.size(); i++)
      if (wr_addr_log[i] !== ADDR_W'(32'h1000 + i * 8)) bad++;
    chk("lfsr_addr_seq", 256'(bad), 256'd0);
    if (wr_dat_log.size() == 34) begin
      chk("lfsr_beat0", wr_dat_log[0], {8{32'h0000_0001}});
      chk("lfsr_beat1", wr_dat_log[1], {8{32'h0000_0002}});
      chk("lfsr_beat31", wr_dat_log[31], {8{32'h8000_0000}});
      chk("lfsr_beat32", wr_dat_log[32], {8{32'h0040_0007}});
      chk("lfsr_beat33", wr_dat_log[33], {8{32'h0080_000E}});
    end
    chk("lfsr_stall_stable", 256'(stall_err), 256'd0);
    chk("lfsr_order", 256'(order_err), 256'd0);
    chk("lfsr_errcnt", 256'(err_count), 256'd0);
    chk("lfsr_error_cleared", 256'(error), 256'd0);

    // read-only, 4 commands but only 3 beats come back -> timeout
    clear();
    ret_budget = 3;
    go(2'b01, 1'b0, 29'h300, 8'd4);
    wait_done("tmo", TIMEOUT + 100, t_done);
    chk("tmo_wait", 256'(t_done - last_cmd_t), 256'((TIMEOUT + 1) * 10));
    chk("tmo_error", 256'(error), 256'd1);
    chk("tmo_no_compare", 256'(err_count), 256'd0);
    // the late fourth beat now arrives while idle
    ret_budget = 1;
    repeat (4) @(negedge ui_clk);
    chk("idle_surplus_busy", 256'(busy), 256'd0);
    chk("idle_surplus_errcnt", 256'(err_count), 256'd0);

    // address wrap at top of space
    clear();
    go(2'b00, 1'b0, 29'h1FFF_FFF8, 8'd2);
    wait_done("wrap", 100, t_done);
    chk("wrap_addr0", 256'(wr_addr_log.size() > 0 ? wr_addr_log[0] : '1), 256'h1FFF_FFF8);
    chk("wrap_addr1", 256'(wr_addr_log.size() > 1 ? wr_addr_log[1] : '1), 256'h0);

    // reserved mode and zero length go straight to FIN
    clear();
    go(2'b11, 1'b0, '0, 8'd4);
    wait_done("rsv", 5, t_done);
    clear();
    go(2'b00, 1'b0, '0, 8'd0);
    wait_done("len0", 5, t_done);
    chk("len0_ncmd", 256'(cmd_cnt), 256'd0);

    // start ignored before calibration
    init_calib_complete = 1'b0;
    go(2'b00, 1'b0, '0, 8'd4);
    @(negedge ui_clk);
    chk("nocal_busy", 256'(busy), 256'd0);
    init_calib_complete = 1'b1;

    // reset in the middle of a write burst
    clear();
    stall_en = 1'b1;
    go(2'b00, 1'b0, '0, 8'd16);
    repeat (4) @(posedge ui_clk);
    #1; ui_clk_sync_rst = 1'b1;
    @(negedge ui_clk); @(negedge ui_clk);
    chk("midrst_app_en", 256'(app_en), 256'd0);
    chk("midrst_wren", 256'(app_wdf_wren), 256'd0);
    chk("midrst_busy", 256'(busy), 256'd0);
    @(posedge ui_clk); #1; ui_clk_sync_rst = 1'b0;
    stall_en = 1'b0;
    n_cmd = cmd_cnt;
    repeat (10) @(negedge ui_clk);
    chk("midrst_no_more_cmds", 256'(cmd_cnt), 256'(n_cmd));
    chk("midrst_still_idle", 256'(busy), 256'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
